// File: rtl/stopwatch_status_tx.sv
// -----------------------------------------------------------------------------
// stopwatch_status_tx
//
// Snapshots the stopwatch seconds count and running flag on request and
// serialises them as the ASCII status record parsed by host software:
//     "<seconds decimal>\nRUNNING=<0|1>\n"
// The binary seconds value is converted to BCD with an iterative double-dabble
// (one bit per cycle); leading zero digits are suppressed.
//
// Optional build macro:
//   STOPWATCH_STATUS_TX_LABEL_EN - prefix the record with "SECONDS=".
//
// Parameters:
//   SEC_WIDTH  - width of the seconds value
//   NUM_DIGITS - BCD digit count, 10**NUM_DIGITS must exceed 2**SEC_WIDTH-1
//
// Ports:
//   clk        - system clock, all logic on posedge
//   rst        - synchronous active-high reset
//   send       - single-cycle request to emit one record (ignored while busy)
//   in_seconds - stopwatch seconds value
//   in_running - stopwatch running flag
//   tx_data    - ASCII byte presented to the sink
//   tx_valid   - tx_data is valid
//   tx_ready   - sink accepts the byte when tx_valid && tx_ready at posedge
//   busy       - a record is being converted or sent
//   done       - one-cycle pulse after the last byte of a record is accepted
// -----------------------------------------------------------------------------
module stopwatch_status_tx #(
    parameter int SEC_WIDTH  = 32,
    parameter int NUM_DIGITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [SEC_WIDTH-1:0] in_seconds,
    input  logic                 in_running,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SEC_WIDTH + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONVERT,
        S_SKIPZ,
`ifdef STOPWATCH_STATUS_TX_LABEL_EN
        S_SLABEL,
`endif
        S_DIGITS,
        S_NL1,
        S_LABEL,
        S_RUN,
        S_NL2
    } state_t;

    state_t               state_q, state_d;
    logic [SEC_WIDTH-1:0] sh_q;        // binary value being shifted out MSB first
    logic [BCD_W-1:0]     bcd_q;       // BCD accumulator
    logic [BCD_W-1:0]     bcd_adj;     // bcd_q after add-3 correction
    logic [CNT_W-1:0]     bit_cnt_q;   // conversion shifts completed
    logic [IDX_W-1:0]     idx_q;       // digit currently presented
    logic [IDX_W-1:0]     msd;         // most significant non-zero digit
    logic [2:0]           lbl_q;       // character position inside a label
    logic                 run_q;       // snapshot of in_running
    logic [3:0]           nibble;
    logic                 accept;
    logic                 emitting;
    logic                 last_byte;

    function automatic logic [7:0] run_label(input logic [2:0] i);
        case (i)
            3'd0:    run_label = 8'h52; // R
            3'd1:    run_label = 8'h55; // U
            3'd2:    run_label = 8'h4E; // N
            3'd3:    run_label = 8'h4E; // N
            3'd4:    run_label = 8'h49; // I
            3'd5:    run_label = 8'h4E; // N
            3'd6:    run_label = 8'h47; // G
            default: run_label = 8'h3D; // =
        endcase
    endfunction

`ifdef STOPWATCH_STATUS_TX_LABEL_EN
    function automatic logic [7:0] sec_label(input logic [2:0] i);
        case (i)
            3'd0:    sec_label = 8'h53; // S
            3'd1:    sec_label = 8'h45; // E
            3'd2:    sec_label = 8'h43; // C
            3'd3:    sec_label = 8'h4F; // O
            3'd4:    sec_label = 8'h4E; // N
            3'd5:    sec_label = 8'h44; // D
            3'd6:    sec_label = 8'h53; // S
            default: sec_label = 8'h3D; // =
        endcase
    endfunction
`endif

    assign accept = tx_valid && tx_ready;
    assign busy   = (state_q != S_IDLE);
    assign nibble = bcd_q[{idx_q, 2'b00} +: 4];

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift so
    // that the shifted nibble carries into the next decade correctly.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
        end
    end

    // Highest non-zero digit; defaults to digit 0 so a zero value prints "0".
    always_comb begin
        msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
        end
    end

    // Next-state and byte selection. The state names the byte on tx_data; the
    // position only moves on an accepting edge, so tx_data is stable while
    // the sink stalls.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        tx_data   = 8'h00;
        emitting  = 1'b0;
        last_byte = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send) state_d = S_CONVERT;
            end
            S_CONVERT: begin
                if (bit_cnt_q == CNT_W'(SEC_WIDTH - 1)) state_d = S_SKIPZ;
            end
            S_SKIPZ: begin
`ifdef STOPWATCH_STATUS_TX_LABEL_EN
                state_d = S_SLABEL;
`else
                state_d = S_DIGITS;
`endif
            end
`ifdef STOPWATCH_STATUS_TX_LABEL_EN
            S_SLABEL: begin
                emitting = 1'b1;
                tx_data  = sec_label(lbl_q);
                if (accept && lbl_q == 3'd7) state_d = S_DIGITS;
            end
`endif
            S_DIGITS: begin
                emitting = 1'b1;
                tx_data  = 8'h30 + {4'h0, nibble};
                if (accept && idx_q == '0) state_d = S_NL1;
            end
            S_NL1: begin
                emitting = 1'b1;
                tx_data  = 8'h0A;
                if (accept) state_d = S_LABEL;
            end
            S_LABEL: begin
                emitting = 1'b1;
                tx_data  = run_label(lbl_q);
                if (accept && lbl_q == 3'd7) state_d = S_RUN;
            end
            S_RUN: begin
                emitting = 1'b1;
                tx_data  = {7'b0011000, run_q};
                if (accept) state_d = S_NL2;
            end
            S_NL2: begin
                emitting  = 1'b1;
                last_byte = 1'b1;
                tx_data   = 8'h0A;
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are cleared along with the FSM so a
            // reset mid-record leaves no stale snapshot behind.
            state_q   <= S_IDLE;
            tx_valid  <= 1'b0;
            done      <= 1'b0;
            sh_q      <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            lbl_q     <= '0;
            run_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            done    <= accept && last_byte;

            // tx_valid rises one cycle after entering the first emitting state
            // and then stays high across byte boundaries until the final byte.
            if (accept && last_byte) begin
                tx_valid <= 1'b0;
            end else if (emitting) begin
                tx_valid <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (send) begin
                        sh_q      <= in_seconds;
                        run_q     <= in_running;
                        bcd_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                S_CONVERT: begin
                    {bcd_q, sh_q} <= {bcd_adj[BCD_W-2:0], sh_q, 1'b0};
                    bit_cnt_q     <= bit_cnt_q + 1'b1;
                end
                S_SKIPZ: begin
                    idx_q <= msd;
                    lbl_q <= '0;
                end
`ifdef STOPWATCH_STATUS_TX_LABEL_EN
                S_SLABEL: begin
                    // 3-bit counter wraps back to 0, ready for the RUNNING label
                    if (accept) lbl_q <= lbl_q + 1'b1;
                end
`endif
                S_DIGITS: begin
                    if (accept && idx_q != '0) idx_q <= idx_q - 1'b1;
                end
                S_LABEL: begin
                    if (accept) lbl_q <= lbl_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
